snake_move_ctrl: RTL

Game-sequencing controller for snake_game. It turns the four button levels into a committed movement direction and paces head moves from VGA frame ticks. It steps the head position through the playfield grid and hands each new head to the collision logic. It then consumes the food/body verdict, growing the snake or ending the game. It sits between the button inputs and the playfield/renderer datapath, in the clk_div domain.

---
 rtl/snake_move_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/snake_move_ctrl.sv
// Snake game sequencer: button presses become a committed direction, frame ticks pace head moves,
// and the collision verdict after each move either grows the snake or ends the game.
//   state | meaning
//   IDLE  | waiting for the first press; everything at reset values
//   PLAY  | counting frames, collecting direction presses
//   CHECK | new head presented (move_stb), collision verdict consumed
//   OVER  | frozen until a press returns to IDLE
module snake_move_ctrl #(
  parameter int GRID_W          = 40,
  parameter int GRID_H          = 30,
  parameter int XW              = 6,
  parameter int YW              = 5,
  parameter int FRAMES_PER_MOVE = 8,
  parameter int START_X         = 20,
  parameter int START_Y         = 15,
  parameter int INIT_LEN        = 3,
  parameter int MAX_LEN         = 16,
  parameter int LW              = 5
) (
  input  logic          clk_div,
  input  logic          rst,
  input  logic          btn_right,
  input  logic          btn_left,
  input  logic          btn_up,
  input  logic          btn_down,
  input  logic          frame_tick,
  input  logic          food_hit,
  input  logic          body_hit,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [1:0]    dir,
  output logic          move_stb,
  output logic          grow,
  output logic [LW-1:0] snake_len,
  output logic          playing,
  output logic          game_over
);

  localparam int FCW = $clog2(FRAMES_PER_MOVE);
  localparam logic [XW-1:0]  X_MAX   = XW'(GRID_W - 1);
  localparam logic [YW-1:0]  Y_MAX   = YW'(GRID_H - 1);
  localparam logic [XW-1:0]  X_START = XW'(START_X);
  localparam logic [YW-1:0]  Y_START = YW'(START_Y);
  localparam logic [LW-1:0]  LEN_INI = LW'(INIT_LEN);
  localparam logic [LW-1:0]  LEN_MAX = LW'(MAX_LEN);
  localparam logic [FCW-1:0] CNT_TOP = FCW'(FRAMES_PER_MOVE - 1);

  typedef enum logic [1:0] {IDLE, PLAY, CHECK, OVER} state_t;

  state_t         state, state_nx;
  logic [3:0]     btn, btn_prev, press;
  logic           press_any;
  logic [1:0]     press_dir;
  logic [1:0]     pending_dir, pending_nx, dir_nx;
  logic [FCW-1:0] frame_cnt, frame_nx;
  logic [XW-1:0]  head_x_nx, step_x;
  logic [YW-1:0]  head_y_nx, step_y;
  logic [LW-1:0]  len_nx;
  logic           grow_nx;
  logic           hit_wall;

  assign btn       = {btn_down, btn_up, btn_left, btn_right};
  assign press     = btn & ~btn_prev;
  assign press_any = |press;

  always_comb begin
    press_dir = 2'b11;
    if (press[0])      press_dir = 2'b00;
    else if (press[1]) press_dir = 2'b01;
    else if (press[2]) press_dir = 2'b10;
  end

  // Wall test is done on the unsigned coordinate before stepping, so no wrap-around is possible.
  always_comb begin
    hit_wall = 1'b0;
    step_x   = head_x;
    step_y   = head_y;
    case (pending_dir)
      2'b00: if (head_x == X_MAX) hit_wall = 1'b1; else step_x = head_x + XW'(1);
      2'b01: if (head_x == '0)    hit_wall = 1'b1; else step_x = head_x - XW'(1);
      2'b10: if (head_y == '0)    hit_wall = 1'b1; else step_y = head_y - YW'(1);
      default: if (head_y == Y_MAX) hit_wall = 1'b1; else step_y = head_y + YW'(1);
    endcase
  end

  always_ff @(posedge clk_div) begin
    if (rst) begin
      state       <= IDLE;
      head_x      <= X_START;
      head_y      <= Y_START;
      dir         <= 2'b00;
      pending_dir <= 2'b00;
      frame_cnt   <= '0;
      snake_len   <= LEN_INI;
      grow        <= 1'b0;
      btn_prev    <= 4'b0000;
    end else begin
      state       <= state_nx;
      head_x      <= head_x_nx;
      head_y      <= head_y_nx;
      dir         <= dir_nx;
      pending_dir <= pending_nx;
      frame_cnt   <= frame_nx;
      snake_len   <= len_nx;
      grow        <= grow_nx;
      btn_prev    <= btn;
    end
  end

  always_comb begin
    state_nx   = state;
    head_x_nx  = head_x;
    head_y_nx  = head_y;
    dir_nx     = dir;
    pending_nx = pending_dir;
    frame_nx   = frame_cnt;
    len_nx     = snake_len;
    grow_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (press_any) begin
          state_nx   = PLAY;
          dir_nx     = press_dir;
          pending_nx = press_dir;
        end
      end
      PLAY: begin
        // Reverse pairs differ only in bit 0: right/left and up/down.
        if (press_any && press_dir != {dir[1], ~dir[0]}) pending_nx = press_dir;
        if (frame_tick) begin
          if (frame_cnt == CNT_TOP) begin
            frame_nx = '0;
            dir_nx   = pending_dir;
            if (hit_wall) begin
              state_nx = OVER;
            end else begin
              head_x_nx = step_x;
              head_y_nx = step_y;
              state_nx  = CHECK;
            end
          end else begin
            frame_nx = frame_cnt + FCW'(1);
          end
        end
      end
      CHECK: begin
        if (frame_tick) frame_nx = frame_cnt + FCW'(1);
        if (body_hit) begin
          state_nx = OVER;
        end else begin
          if (food_hit) begin
            grow_nx = 1'b1;
            if (snake_len < LEN_MAX) len_nx = snake_len + LW'(1);
          end
          state_nx = PLAY;
        end
      end
      default: begin
        if (press_any) begin
          state_nx   = IDLE;
          head_x_nx  = X_START;
          head_y_nx  = Y_START;
          dir_nx     = 2'b00;
          pending_nx = 2'b00;
          frame_nx   = '0;
          len_nx     = LEN_INI;
        end
      end
    endcase
  end

  // CHECK is entered only by a successful move, so it doubles as the move strobe.
  always_comb begin
    playing   = (state == PLAY) || (state == CHECK);
    game_over = (state == OVER);
    move_stb  = (state == CHECK);
  end

endmodule
